// File: rtl/rx_packet_ctrl.sv
// Frame sequencer behind the UART byte receiver: SYNC, ID, LEN, PAYLOAD, CHK.
// Presents only address-, length- and checksum-verified payloads, with an inter-byte timeout.
module rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] BOT_ID    = 8'h01,
  parameter int         MAX_LEN   = 8,
  parameter int         TIMEOUT   = 20000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           rx_byte_i,
  input  logic                 rx_done_i,
  output logic [8*MAX_LEN-1:0] pkt_data_o,
  output logic [3:0]           pkt_len_o,
  output logic                 pkt_valid_o,
  output logic                 err_chk_o,
  output logic                 err_len_o,
  output logic                 err_timeout_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ID, S_LEN, S_PAYLOAD, S_CHK} state_t;

  state_t               state_q;
  logic                 match_q;
  logic [7:0]           chkAcc_q;
  logic [3:0]           len_q;
  logic [3:0]           idx_q;
  logic [CW-1:0]        cnt_q;
  logic [8*MAX_LEN-1:0] shadow_q;
  logic [8*MAX_LEN-1:0] pktData_q;
  logic [3:0]           pktLen_q;
  logic                 pktValid_q;
  logic                 errChk_q;
  logic                 errLen_q;
  logic                 errTimeout_q;

  logic [7:0]           chkAcc_d;
  logic [8*MAX_LEN-1:0] shadowFill_d;

  always_comb begin
    chkAcc_d = chkAcc_q ^ rx_byte_i;
    shadowFill_d = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (4'(k) < len_q) shadowFill_d[8*k +: 8] = shadow_q[8*k +: 8];
    end
  end

  // A received byte always takes priority over timeout expiry in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      match_q      <= 1'b0;
      chkAcc_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      pktData_q    <= '0;
      pktLen_q     <= '0;
      pktValid_q   <= 1'b0;
      errChk_q     <= 1'b0;
      errLen_q     <= 1'b0;
      errTimeout_q <= 1'b0;
    end else begin
      pktValid_q   <= 1'b0;
      errChk_q     <= 1'b0;
      errLen_q     <= 1'b0;
      errTimeout_q <= 1'b0;
      if (rx_done_i) begin
        cnt_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (rx_byte_i == SYNC_BYTE) state_q <= S_ID;
          end
          S_ID: begin
            match_q  <= (rx_byte_i == BOT_ID) || (rx_byte_i == 8'hFF);
            chkAcc_q <= rx_byte_i;
            state_q  <= S_LEN;
          end
          S_LEN: begin
            if (rx_byte_i == 8'd0 || rx_byte_i > 8'(MAX_LEN)) begin
              errLen_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              len_q    <= rx_byte_i[3:0];
              chkAcc_q <= chkAcc_d;
              idx_q    <= '0;
              state_q  <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            for (int k = 0; k < MAX_LEN; k++) begin
              if (idx_q == 4'(k)) shadow_q[8*k +: 8] <= rx_byte_i;
            end
            chkAcc_q <= chkAcc_d;
            idx_q    <= idx_q + 4'd1;
            if (idx_q == len_q - 4'd1) state_q <= S_CHK;
          end
          S_CHK: begin
            if (match_q) begin
              if (rx_byte_i == chkAcc_q) begin
                pktData_q  <= shadowFill_d;
                pktLen_q   <= len_q;
                pktValid_q <= 1'b1;
              end else begin
                errChk_q <= 1'b1;
              end
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        errTimeout_q <= 1'b1;
        cnt_q        <= '0;
        state_q      <= S_IDLE;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pkt_data_o    = pktData_q;
  assign pkt_len_o     = pktLen_q;
  assign pkt_valid_o   = pktValid_q;
  assign err_chk_o     = errChk_q;
  assign err_len_o     = errLen_q;
  assign err_timeout_o = errTimeout_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Self-checking bench for rx_packet_ctrl: table-driven frames plus
// hand-written timeout, back-to-back and mid-frame reset sequences.
module tb_rx_packet_ctrl;

  localparam int MAX_LEN = 8;
  localparam int TIMEOUT = 20000;

  logic                 clk = 1'b0;
  logic                 rstN;
  logic [7:0]           rxByte;
  logic                 rxDone;
  logic [8*MAX_LEN-1:0] pktData;
  logic [3:0]           pktLen;
  logic                 pktValid;
  logic                 errChk;
  logic                 errLen;
  logic                 errTimeout;
  logic                 busy;

  int compared = 0;
  int mismatched = 0;
  int validCnt = 0;
  int chkCnt = 0;
  int lenCnt = 0;
  int toCnt = 0;

  rx_packet_ctrl #(
    .SYNC_BYTE(8'hA5),
    .BOT_ID   (8'h01),
    .MAX_LEN  (MAX_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .rx_byte_i    (rxByte),
    .rx_done_i    (rxDone),
    .pkt_data_o   (pktData),
    .pkt_len_o    (pktLen),
    .pkt_valid_o  (pktValid),
    .err_chk_o    (errChk),
    .err_len_o    (errLen),
    .err_timeout_o(errTimeout),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [103:0] bytes;
    int          expValid;
    int          expChk;
    int          expLen;
    logic [3:0]  expPktLen;
    logic [63:0] expData;
  } vec_t;

  vec_t vecs[10];

  // Strobe tally sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rstN) begin
      validCnt += int'(pktValid);
      chkCnt   += int'(errChk);
      lenCnt   += int'(errLen);
      toCnt    += int'(errTimeout);
      compared++;
      if ($countones({pktValid, errChk, errLen, errTimeout}) > 1) begin
        mismatched++;
        $display("[TB] FAIL strobeOneHot: got %b required at most one high",
                 {pktValid, errChk, errLen, errTimeout});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  // Entered on a falling edge; leaves on a falling edge after the idle gap.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rxByte = b;
    rxDone = 1'b1;
    @(negedge clk);
    rxDone = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int v0, c0, l0, t0, hit;

    vecs[0] = '{"goodPkt",   6, 104'h00_A50102102033, 1, 0, 0, 4'd2, 64'h2010};
    vecs[1] = '{"badChk",    6, 104'h00_A50102102034, 0, 1, 0, 4'd2, 64'h2010};
    vecs[2] = '{"otherId",   5, 104'h00_A507015553,   0, 0, 0, 4'd2, 64'h2010};
    vecs[3] = '{"broadcast", 5, 104'h00_A5FF0155AB,   1, 0, 0, 4'd1, 64'h55};
    vecs[4] = '{"lenZero",   3, 104'h00_A50100,       0, 0, 1, 4'd1, 64'h55};
    vecs[5] = '{"lenNine",   3, 104'h00_A50109,       0, 0, 1, 4'd1, 64'h55};
    vecs[6] = '{"lenOne",    5, 104'h00_A501017E7E,   1, 0, 0, 4'd1, 64'h7E};
    vecs[7] = '{"lenMax",   12, 104'h00_A50108112233445566778881, 1, 0, 0, 4'd8, 64'h8877665544332211};
    vecs[8] = '{"midSync",   6, 104'h00_A50102A501A7, 1, 0, 0, 4'd2, 64'h01A5};
    vecs[9] = '{"noise",     6, 104'h00_13A501015A5A, 1, 0, 0, 4'd1, 64'h5A};

    rstN = 1'b0;
    rxByte = 8'h00;
    rxDone = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetData",  pktData, 64'h0);
    checkOutput("resetLen",   64'(pktLen), 64'h0);
    checkOutput("resetStrb",  64'({pktValid, errChk, errLen, errTimeout}), 64'h0);
    checkOutput("resetBusy",  64'(busy), 64'h0);
    rstN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      v0 = validCnt; c0 = chkCnt; l0 = lenCnt; t0 = toCnt;
      for (int j = 0; j < vecs[i].n; j++)
        applyStimulus(vecs[i].bytes[8*(vecs[i].n-1-j) +: 8], 1);
      settle();
      checkOutput({vecs[i].name, ".valid"},   64'(validCnt - v0), 64'(vecs[i].expValid));
      checkOutput({vecs[i].name, ".errChk"},  64'(chkCnt - c0),   64'(vecs[i].expChk));
      checkOutput({vecs[i].name, ".errLen"},  64'(lenCnt - l0),   64'(vecs[i].expLen));
      checkOutput({vecs[i].name, ".timeout"}, 64'(toCnt - t0),    64'h0);
      checkOutput({vecs[i].name, ".pktLen"},  64'(pktLen),        64'(vecs[i].expPktLen));
      checkOutput({vecs[i].name, ".pktData"}, pktData,            vecs[i].expData);
      checkOutput({vecs[i].name, ".busy"},    64'(busy),          64'h0);
    end

    // Busy rises the cycle after SYNC; frames back to back with no idle cycles.
    v0 = validCnt;
    applyStimulus(8'hA5, 0);
    checkOutput("busyAfterSync", 64'(busy), 64'h1);
    applyStimulus(8'h01, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h11, 0); applyStimulus(8'h11, 0);
    applyStimulus(8'hA5, 0); applyStimulus(8'h01, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h22, 0); applyStimulus(8'h22, 0);
    settle();
    checkOutput("b2b.valid",   64'(validCnt - v0), 64'h2);
    checkOutput("b2b.pktData", pktData, 64'h22);

    // Plain timeout: strobe exactly TIMEOUT edges after the last byte.
    t0 = toCnt;
    hit = 0;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      @(posedge clk);
      #1;
      if (errTimeout) begin
        hit = k;
        break;
      end
    end
    checkOutput("timeoutCycle", 64'(hit), 64'(TIMEOUT));
    checkOutput("timeoutBusy",  64'(busy), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("timeoutOneCycle", 64'(errTimeout), 64'h0);
    @(negedge clk);
    settle();
    checkOutput("timeout.count", 64'(toCnt - t0), 64'h1);
    checkOutput("timeout.data",  pktData, 64'h22);

    // Gap of TIMEOUT-2 idle cycles, then TIMEOUT-1 where the byte collides with expiry.
    v0 = validCnt; t0 = toCnt;
    applyStimulus(8'hA5, 1); applyStimulus(8'h01, 1);
    applyStimulus(8'h01, TIMEOUT - 2);
    applyStimulus(8'h4D, 1); applyStimulus(8'h4D, 1);
    settle();
    checkOutput("gapShort.valid",   64'(validCnt - v0), 64'h1);
    checkOutput("gapShort.timeout", 64'(toCnt - t0),    64'h0);
    checkOutput("gapShort.data",    pktData, 64'h4D);
    v0 = validCnt; t0 = toCnt;
    applyStimulus(8'hA5, 1); applyStimulus(8'h01, 1);
    applyStimulus(8'h01, TIMEOUT - 1);
    applyStimulus(8'h3C, 1); applyStimulus(8'h3C, 1);
    settle();
    checkOutput("byteWins.valid",   64'(validCnt - v0), 64'h1);
    checkOutput("byteWins.timeout", 64'(toCnt - t0),    64'h0);
    checkOutput("byteWins.data",    pktData, 64'h3C);

    // Reset mid-frame abandons the frame and clears the accepted payload.
    applyStimulus(8'hA5, 1); applyStimulus(8'h01, 1);
    applyStimulus(8'h03, 1); applyStimulus(8'h11, 1);
    checkOutput("midFrameBusy", 64'(busy), 64'h1);
    rstN = 1'b0;
    #1;
    checkOutput("midRst.data", pktData, 64'h0);
    checkOutput("midRst.len",  64'(pktLen), 64'h0);
    checkOutput("midRst.busy", 64'(busy), 64'h0);
    checkOutput("midRst.strb", 64'({pktValid, errChk, errLen, errTimeout}), 64'h0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    v0 = validCnt;
    applyStimulus(8'hA5, 1); applyStimulus(8'h01, 1); applyStimulus(8'h01, 1);
    applyStimulus(8'h42, 1); applyStimulus(8'h42, 1);
    settle();
    checkOutput("afterRst.valid", 64'(validCnt - v0), 64'h1);
    checkOutput("afterRst.data",  pktData, 64'h42);
    checkOutput("afterRst.len",   64'(pktLen), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rx_packet_ctrl.md
# rx_packet_ctrl

Frame-level controller that sits behind the UART byte receiver and sequences its output into complete command packets for the robot. It consumes the receiver's byte/done pulses and tracks the frame SYNC, ID, LEN, PAYLOAD, CHK. It validates address, length and XOR checksum, and enforces an inter-byte timeout. Only fully verified payloads are presented to the motor/command logic, as a parallel register plus a one-cycle strobe.

## Interface
- SYNC_BYTE, 8'hA5, start-of-frame marker
- BOT_ID, 8'h01, this robot's address; 8'hFF is broadcast and is always accepted
- MAX_LEN, 8, maximum payload bytes (1..15)
- TIMEOUT, 20000, max clk cycles allowed between consecutive bytes inside a frame
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_byte  in  8  received byte; valid only in the cycle rx_done is high
- rx_done  in  1  one-cycle strobe, one per received byte
- pkt_data  out  8*MAX_LEN  last accepted payload; byte k at [8k+7:8k]; bytes ≥ pkt_len are zero
- pkt_len  out  4  payload length of last accepted packet
- pkt_valid  out  1  one-cycle strobe: pkt_data/pkt_len just updated
- err_chk  out  1  one-cycle strobe: checksum mismatch on an addressed frame
- err_len  out  1  one-cycle strobe: LEN = 0 or LEN > MAX_LEN
- err_timeout  out  1  one-cycle strobe: inter-byte gap exceeded
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ID, LEN, PAYLOAD, CHK. All transitions occur only on rx_done, except the timeout transition.
- IDLE: rx_done with rx_byte == SYNC_BYTE → ID. Any other byte is ignored.
- ID: latch match = (rx_byte == BOT_ID) or (rx_byte == 8'hFF). Set chk_acc = rx_byte. → LEN.
- LEN: if rx_byte == 0 or rx_byte > MAX_LEN, pulse err_len and → IDLE. Otherwise latch len, set chk_acc ^= rx_byte, clear byte index, → PAYLOAD.
- PAYLOAD: write rx_byte into the internal shadow buffer at the byte index. Set chk_acc ^= rx_byte. Increment the index; when index == len-1 on this byte → CHK.
- CHK, when match = 1:
  - rx_byte == chk_acc: copy the shadow buffer (zero-filled above len) to pkt_data, copy len to pkt_len, pulse pkt_valid.
  - otherwise: pulse err_chk; pkt_data and pkt_len are unchanged.
- CHK, when match = 0: the frame is dropped silently, with no strobes.
- CHK always → IDLE.
- Shadow buffer rule: pkt_data/pkt_len change only on pkt_valid. Partial or bad frames never disturb them.
- A SYNC_BYTE value seen mid-frame is treated as ordinary data. There is no resynchronisation inside a frame.
- Timeout counter:
  - Clears on every rx_done and while in IDLE.
  - Otherwise increments, saturating.
  - On reaching TIMEOUT-1 in any non-IDLE state: pulse err_timeout → IDLE.
- Width: the counter is clog2(TIMEOUT) bits; the byte index is 4 bits.

## Timing
- Reset (async, rst_n low): state = IDLE; pkt_data = 0, pkt_len = 0; all strobes 0; busy = 0; timeout counter = 0; chk_acc = 0.
- Release is synchronous to the next clk edge.
- Registered outputs. pkt_valid, err_chk, err_len and err_timeout assert in the cycle after the clk edge that samples the deciding rx_done, and last exactly one cycle.
- pkt_data and pkt_len update on the same edge that raises pkt_valid.
- busy rises one cycle after the SYNC rx_done. It falls in the same cycle any terminating strobe is high.
- Back-to-back frames: a SYNC byte arriving on the rx_done immediately after the CHK byte is accepted. There is no dead cycle beyond the receiver's own.
- Simultaneous rx_done and timeout expiry: the byte wins, the counter clears, and no err_timeout is raised.
- Reset asserted mid-frame: the frame is abandoned with no strobes; the previously accepted pkt_data is cleared to 0.
- At most one strobe is high in any cycle.

## Test plan
- Good packet: A5 01 02 10 20 33 → pkt_valid for 1 cycle; pkt_len = 2; pkt_data[15:0] = 16'h2010; upper bytes 0; busy low after the strobe.
- Bad checksum: A5 01 02 10 20 34 → err_chk pulse; pkt_data/pkt_len keep the prior values; no pkt_valid.
- Address filtering:
  - A5 07 01 55 53 → no strobes.
  - A5 FF 01 55 AB → pkt_valid with pkt_data[7:0] = 8'h55.
- Length errors:
  - A5 01 00 → err_len, state returns to IDLE.
  - A5 01 09 with MAX_LEN = 8 → err_len.
  - Following A5 01 01 7E 7E → accepted.
- Timeout:
  - Send A5 01, then idle TIMEOUT cycles → single err_timeout, busy low.
  - A gap of TIMEOUT-2 cycles between bytes → no timeout.
- Reset mid-frame: assert rst_n low after A5 01 03 11 → all outputs 0 immediately; after release, a good frame A5 01 01 42 42 produces pkt_valid.
